// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access-size encodings,
// controller state type, default geometry and an alignment helper.
package dmem_pkg;

    localparam logic [1:0]  FMT_WORD = 2'b00;
    localparam logic [1:0]  FMT_HALF = 2'b01;
    localparam logic [1:0]  FMT_BYTE = 2'b10;
    localparam logic [1:0]  FMT_RSVD = 2'b11;

    localparam int          DEFAULT_DEPTH     = 1024;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_MERGE = 1'b1
    } state_t;

    // Words need a 4-byte aligned address, halves an even one; bytes never misalign.
    function automatic logic is_misaligned(input logic [1:0] fmt, input logic [1:0] lane);
        logic bad;
        bad = 1'b0;
        case (fmt)
            FMT_WORD: bad = (lane != 2'b00);
            FMT_HALF: bad = lane[0];
            default:  bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lane_merge.sv
// Little-endian lane handling: inserts right-aligned store data into an old
// word and extracts right-aligned, zero-filled load data from a word.
module dmem_lane_merge
    import dmem_pkg::*;
(
    input  logic [31:0] i_old_word,
    input  logic [31:0] i_st_data,
    input  logic [1:0]  i_fmt,
    input  logic [1:0]  i_lane,
    output logic [31:0] o_merged,
    output logic [31:0] o_load
);

    // Lane select for both the store merge and the load extraction.
    always_comb begin
        o_merged = i_old_word;
        o_load   = 32'h0000_0000;
        case (i_fmt)
            FMT_WORD: begin
                o_merged = i_st_data;
                o_load   = i_old_word;
            end
            FMT_HALF: begin
                if (i_lane[1]) begin
                    o_merged[31:16] = i_st_data[15:0];
                    o_load          = {16'h0000, i_old_word[31:16]};
                end else begin
                    o_merged[15:0]  = i_st_data[15:0];
                    o_load          = {16'h0000, i_old_word[15:0]};
                end
            end
            FMT_BYTE: begin
                case (i_lane)
                    2'd0: begin
                        o_merged[7:0]   = i_st_data[7:0];
                        o_load          = {24'h00_0000, i_old_word[7:0]};
                    end
                    2'd1: begin
                        o_merged[15:8]  = i_st_data[7:0];
                        o_load          = {24'h00_0000, i_old_word[15:8]};
                    end
                    2'd2: begin
                        o_merged[23:16] = i_st_data[7:0];
                        o_load          = {24'h00_0000, i_old_word[23:16]};
                    end
                    2'd3: begin
                        o_merged[31:24] = i_st_data[7:0];
                        o_load          = {24'h00_0000, i_old_word[31:24]};
                    end
                    default: begin
                        o_merged = i_old_word;
                        o_load   = 32'h0000_0000;
                    end
                endcase
            end
            default: begin
                o_merged = i_old_word;
                o_load   = 32'h0000_0000;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Word-organised data memory with byte/half/word access. Word stores and all
// loads complete at the accepting edge; half/byte stores take one extra
// MERGE cycle for the read-modify-write. Illegal accesses pulse addr_err.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH     = DEFAULT_DEPTH,
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_addr,
    input  logic [31:0] w_data,
    input  logic        dmem_w,
    input  logic        dmem_r,
    input  logic [1:0]  store_format_signal,
    output logic [31:0] dmem_data,
    output logic        ready,
    output logic        addr_err
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [31:0]      r_mem [DEPTH];
    state_t           r_state;
    state_t           w_state_next;
    logic [31:0]      r_dmem_data;
    logic             r_addr_err;
    logic [IDX_W-1:0] r_pend_idx;
    logic [31:0]      r_pend_data;
    logic [31:0]      r_old_word;
    logic [1:0]       r_pend_fmt;
    logic [1:0]       r_pend_lane;

    logic [31:0]      w_offset;
    logic [IDX_W-1:0] w_index;
    logic [1:0]       w_lane;
    logic             w_bad;
    logic             w_word_store;
    logic             w_part_store;
    logic             w_merge_write;
    logic             w_load;
    logic             w_err;
    logic [31:0]      w_rd_word;
    logic [31:0]      w_mrg_old;
    logic [31:0]      w_mrg_data;
    logic [1:0]       w_mrg_fmt;
    logic [1:0]       w_mrg_lane;
    logic [31:0]      w_merged;
    logic [31:0]      w_load_data;

    // BASE_ADDR is word aligned, so the low offset bits equal the address lane.
    assign w_offset  = data_addr - BASE_ADDR;
    assign w_index   = w_offset[IDX_W+1:2];
    assign w_lane    = w_offset[1:0];
    assign w_bad     = (data_addr < BASE_ADDR)
                     || ((w_offset >> 2) >= 32'(DEPTH))
                     || (store_format_signal == FMT_RSVD)
                     || is_misaligned(store_format_signal, w_lane);
    assign w_rd_word = r_mem[w_index];

    // In MERGE the lane unit works on the captured request, otherwise on the live one.
    assign w_mrg_old  = (r_state == ST_MERGE) ? r_old_word  : w_rd_word;
    assign w_mrg_data = (r_state == ST_MERGE) ? r_pend_data : w_data;
    assign w_mrg_fmt  = (r_state == ST_MERGE) ? r_pend_fmt  : store_format_signal;
    assign w_mrg_lane = (r_state == ST_MERGE) ? r_pend_lane : w_lane;

    dmem_lane_merge u_lane_merge (
        .i_old_word (w_mrg_old),
        .i_st_data  (w_mrg_data),
        .i_fmt      (w_mrg_fmt),
        .i_lane     (w_mrg_lane),
        .o_merged   (w_merged),
        .o_load     (w_load_data)
    );

    // Controller next state and one-cycle action strobes.
    always_comb begin
        w_state_next  = r_state;
        w_word_store  = 1'b0;
        w_part_store  = 1'b0;
        w_merge_write = 1'b0;
        w_load        = 1'b0;
        w_err         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (rst && (dmem_w || dmem_r)) begin
                    if (w_bad) begin
                        w_err = 1'b1;
                    end else if (dmem_w) begin
                        if (store_format_signal == FMT_WORD) begin
                            w_word_store = 1'b1;
                        end else begin
                            w_part_store = 1'b1;
                            w_state_next = ST_MERGE;
                        end
                    end else begin
                        w_load = 1'b1;
                    end
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_MERGE: begin
                w_merge_write = 1'b1;
                w_state_next  = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Controller state register; reset abandons any pending merge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Storage array, intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_word_store) begin
            r_mem[w_index] <= w_data;
        end else if (w_merge_write) begin
            r_mem[r_pend_idx] <= w_merged;
        end
    end

    // Registered load data, error pulse and captured partial-store request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dmem_data <= 32'h0000_0000;
            r_addr_err  <= 1'b0;
            r_pend_idx  <= '0;
            r_pend_data <= 32'h0000_0000;
            r_old_word  <= 32'h0000_0000;
            r_pend_fmt  <= 2'b00;
            r_pend_lane <= 2'b00;
        end else begin
            r_addr_err <= w_err;
            if (w_load) begin
                r_dmem_data <= w_load_data;
            end
            if (w_part_store) begin
                r_pend_idx  <= w_index;
                r_pend_data <= w_data;
                r_old_word  <= w_rd_word;
                r_pend_fmt  <= store_format_signal;
                r_pend_lane <= w_lane;
            end
        end
    end

    assign dmem_data = r_dmem_data;
    assign addr_err  = r_addr_err;
    assign ready     = (r_state == ST_IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_dmem_responder;

    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h1001_0000;

    logic        clk;
    logic        rst;
    logic [31:0] data_addr;
    logic [31:0] w_data;
    logic        dmem_w;
    logic        dmem_r;
    logic [1:0]  store_format_signal;
    logic [31:0] dmem_data;
    logic        ready;
    logic        addr_err;

    int n_pass;
    int n_total;
    bit chk_en;

    // Reference model state
    logic [31:0] m_mem [DEPTH];
    bit          m_busy;
    int          m_pidx;
    logic [31:0] m_pword;
    logic [31:0] exp_data;
    logic        exp_err;

    dmem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .data_addr           (data_addr),
        .w_data              (w_data),
        .dmem_w              (dmem_w),
        .dmem_r              (dmem_r),
        .store_format_signal (store_format_signal),
        .dmem_data           (dmem_data),
        .ready               (ready),
        .addr_err            (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Transaction-level model: byte offset arithmetic, size masks and a
    // one-cycle deferred commit for partial stores.
    always @(posedge clk or negedge rst) begin
        longint      off;
        int          sz;
        int          idx;
        int          sh;
        logic [31:0] mask;
        logic [31:0] nw;
        if (!rst) begin
            m_busy   <= 1'b0;
            exp_data <= 32'h0;
            exp_err  <= 1'b0;
        end else begin
            exp_err <= 1'b0;
            if (m_busy) begin
                m_mem[m_pidx] <= m_pword;
                m_busy        <= 1'b0;
            end else if (dmem_w || dmem_r) begin
                off = longint'({32'h0, data_addr}) - longint'({32'h0, BASE});
                sz  = (store_format_signal == 2'd0) ? 4 : (store_format_signal == 2'd1) ? 2 : 1;
                if (store_format_signal == 2'd3 || off < 0 || off >= longint'(DEPTH * 4) || (off % sz) != 0) begin
                    exp_err <= 1'b1;
                end else begin
                    idx  = int'(off / 4);
                    sh   = int'(off % 4) * 8;
                    mask = (sz == 4) ? 32'hFFFF_FFFF : (sz == 2) ? 32'h0000_FFFF : 32'h0000_00FF;
                    if (dmem_w) begin
                        nw = (m_mem[idx] & ~(mask << sh)) | ((w_data & mask) << sh);
                        if (sz == 4) begin
                            m_mem[idx] <= nw;
                        end else begin
                            m_busy  <= 1'b1;
                            m_pidx  <= idx;
                            m_pword <= nw;
                        end
                    end else begin
                        exp_data <= (m_mem[idx] >> sh) & mask;
                    end
                end
            end
        end
    end

    // Per-cycle comparison of the DUT outputs against the model.
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check("cyc_ready", {31'h0, ready}, {31'h0, !m_busy});
            check("cyc_err", {31'h0, addr_err}, {31'h0, exp_err});
            check("cyc_data", dmem_data, exp_data);
        end
    end

    task automatic do_req(input logic w, input logic r, input logic [1:0] fmt,
                          input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        dmem_w = w; dmem_r = r; store_format_signal = fmt; data_addr = addr; w_data = data;
        @(posedge clk);
        #2;
        dmem_w = 1'b0; dmem_r = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int op;
        int fr;
        n_pass = 0; n_total = 0; chk_en = 1'b0;
        rst = 1'b0; dmem_w = 1'b0; dmem_r = 1'b0; store_format_signal = 2'b00;
        data_addr = 32'h0; w_data = 32'h0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_data", dmem_data, 32'h0);
        check("rst_err", {31'h0, addr_err}, 32'h0);
        check("rst_ready", {31'h0, ready}, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        chk_en = 1'b1;

        // Give every word a defined value.
        for (int i = 0; i < DEPTH; i++) do_req(1'b1, 1'b0, 2'd0, BASE + 32'(4 * i), $urandom);

        // Word store then word load.
        do_req(1'b1, 1'b0, 2'd0, 32'h1001_0004, 32'hDEAD_BEEF);
        do_req(1'b0, 1'b1, 2'd0, 32'h1001_0004, 32'h0);
        check("w_load", dmem_data, 32'hDEAD_BEEF);
        check("w_load_model", exp_data, 32'hDEAD_BEEF);
        check("w_load_err", {31'h0, addr_err}, 32'h0);

        // Byte store with one stall cycle.
        do_req(1'b1, 1'b0, 2'd2, 32'h1001_0006, 32'h0000_005A);
        check("b_stall", {31'h0, ready}, 32'h0);
        idle_cycle();
        check("b_stall_end", {31'h0, ready}, 32'h1);
        do_req(1'b0, 1'b1, 2'd0, 32'h1001_0004, 32'h0);
        check("b_merged", dmem_data, 32'hDE5A_BEEF);
        check("b_merged_model", exp_data, 32'hDE5A_BEEF);

        // Half store onto all-ones.
        do_req(1'b1, 1'b0, 2'd0, 32'h1001_0000, 32'hFFFF_FFFF);
        do_req(1'b1, 1'b0, 2'd1, 32'h1001_0002, 32'h0000_1234);
        idle_cycle();
        do_req(1'b0, 1'b1, 2'd1, 32'h1001_0002, 32'h0);
        check("h_load", dmem_data, 32'h0000_1234);
        do_req(1'b0, 1'b1, 2'd0, 32'h1001_0000, 32'h0);
        check("h_word", dmem_data, 32'h1234_FFFF);
        check("h_word_model", exp_data, 32'h1234_FFFF);

        // Rejected accesses.
        do_req(1'b1, 1'b0, 2'd0, 32'h1001_0002, 32'hAAAA_AAAA);
        check("mis_err", {31'h0, addr_err}, 32'h1);
        idle_cycle();
        check("mis_err_pulse", {31'h0, addr_err}, 32'h0);
        do_req(1'b0, 1'b1, 2'd0, 32'h0FFF_FFFC, 32'h0);
        check("oor_err", {31'h0, addr_err}, 32'h1);
        check("oor_data", dmem_data, 32'h1234_FFFF);
        idle_cycle();
        check("oor_err_pulse", {31'h0, addr_err}, 32'h0);
        do_req(1'b0, 1'b1, 2'd0, 32'h1001_0000, 32'h0);
        check("mis_mem", dmem_data, 32'h1234_FFFF);
        do_req(1'b0, 1'b1, 2'd0, BASE + 32'(4 * DEPTH), 32'h0);
        check("top_err", {31'h0, addr_err}, 32'h1);

        // Reset during MERGE discards the pending write.
        do_req(1'b1, 1'b0, 2'd0, 32'h1001_0000, 32'hCAFE_F00D);
        do_req(1'b1, 1'b0, 2'd2, 32'h1001_0000, 32'h0000_0077);
        rst = 1'b0;
        #1;
        check("mrst_data", dmem_data, 32'h0);
        check("mrst_err", {31'h0, addr_err}, 32'h0);
        check("mrst_ready", {31'h0, ready}, 32'h1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mrst_ready_rel", {31'h0, ready}, 32'h1);
        do_req(1'b0, 1'b1, 2'd0, 32'h1001_0000, 32'h0);
        check("mrst_mem", dmem_data, 32'hCAFE_F00D);

        // Randomized traffic, including requests while stalled and w+r together.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            op = int'($urandom_range(0, 3));
            fr = int'($urandom_range(0, 9));
            dmem_w = (op == 1 || op == 3);
            dmem_r = (op == 2 || op == 3);
            store_format_signal = (fr < 3) ? 2'd0 : (fr < 6) ? 2'd1 : (fr < 9) ? 2'd2 : 2'd3;
            if ($urandom_range(0, 19) == 0) data_addr = BASE - 32'($urandom_range(1, 16));
            else data_addr = BASE + 32'($urandom_range(0, DEPTH * 4 + 7));
            w_data = $urandom;
        end
        @(negedge clk);
        dmem_w = 1'b0; dmem_r = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter: DEPTH, default 1024, storage size in 32-bit words (power of 2).
REQ-002 Parameter: BASE_ADDR, default 32'h1001_0000, byte address of word 0.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-low reset.
REQ-005 Port: data_addr  input  32  byte address of the access.
REQ-006 Port: w_data  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-007 Port: dmem_w  input  1  store request.
REQ-008 Port: dmem_r  input  1  load request.
REQ-009 Port: store_format_signal  input  2  access size: 00 word, 01 halfword, 10 byte, 11 reserved.
REQ-010 Port: dmem_data  output  32  registered load data, right-aligned, zero-filled above access size.
REQ-011 Port: ready  output  1  high when a new request can be accepted.
REQ-012 Port: addr_err  output  1  one-cycle pulse flagging a rejected access.

Function
REQ-013 Request SHALL be accepted on a rising edge where ready=1 and (dmem_w or dmem_r); otherwise ignored.
REQ-014 FSM states SHALL be IDLE and MERGE; ready=1 in IDLE, 0 in MERGE.
REQ-015 Word index SHALL be (data_addr - BASE_ADDR) >> 2; an access is out of range if the index is not below DEPTH or data_addr < BASE_ADDR.
REQ-016 Misaligned access (word with addr[1:0]!=0, half with addr[0]!=0), out-of-range access, or format 11 SHALL be dropped, addr_err=1 the next cycle, no memory or dmem_data change.
REQ-017 Word store: memory word written at the accepting edge; FSM stays IDLE.
REQ-018 Half/byte store: accepting edge captures the stored word and the request; FSM enters MERGE; next edge writes the merged word and returns to IDLE (exactly one stall cycle).
REQ-019 Lane mapping is little-endian: halfword lane = addr[1] (0 -> [15:0], 1 -> [31:16]); byte lane = addr[1:0]; unselected lanes SHALL be preserved.
REQ-020 Load: dmem_data updated at the accepting edge (valid the cycle after request) to word >> (8*addr[1:0]) for bytes, >> (16*addr[1]) for halves, masked to size; holds until the next accepted load.
REQ-021 dmem_w and dmem_r both high: store executes, load ignored, dmem_data held.
REQ-022 Load accepted in the cycle following MERGE SHALL observe the merged word (no stale data).
REQ-023 Requests while ready=0 SHALL be ignored; the requester is responsible for holding them.

Reset
REQ-024 rst low SHALL asynchronously force FSM=IDLE, dmem_data=0, addr_err=0; ready=1 once rst is high.
REQ-025 Reset during MERGE SHALL discard the pending write; the target word keeps its pre-request value.
REQ-026 Storage array contents SHALL NOT be reset.

Structure
REQ-027 Package dmem_pkg: format encodings (FMT_WORD/HALF/BYTE), FSM state type, default BASE_ADDR and DEPTH.
REQ-028 One combinational sub-module dmem_lane_merge: merges store data into an old word and extracts load data by format and addr[1:0].

Verification
REQ-029 Word store 0xDEADBEEF @0x10010004, then word load @0x10010004 -> dmem_data=0xDEADBEEF one cycle after accept, addr_err=0.
REQ-030 After REQ-029, byte store 0x5A @0x10010006 -> ready=0 for exactly one cycle; word load -> 0xDE5ABEEF.
REQ-031 Half store 0x1234 @0x10010002 onto 0xFFFFFFFF; half load @0x10010002 -> 0x00001234; word load -> 0x1234FFFF.
REQ-032 Word store @0x10010002, and word load @0x0FFFFFFC -> addr_err pulses one cycle each, memory and dmem_data unchanged.
REQ-033 Byte store 0x77 @0x10010000 with rst asserted during MERGE -> word @0x10010000 unchanged, dmem_data=0, ready=1 after release.
